// File: rtl/lsu_trigger_resolve.sv
// lsu_trigger_resolve
//   Takes the raw per-trigger match bits from the LSU trigger matcher in dc3,
//   applies pairwise chaining and stages the result through dc4 and dc5.
//   Flushes kill the staged matches. The dc5 result goes to dec. Triggers
//   whose action is enter-debug also drive a debug-halt request handshake.
//   A debug match that arrives while a request is still unacknowledged is
//   dropped and counted.
// Ports
//   clk                   core clock
//   rst_l                 asynchronous active-low reset
//   lsu_trigger_match_dc3 raw per-trigger match, dc3
//   lsu_pkt_valid_dc3     valid non-DMA LSU op in dc3
//   trigger_chain         even bit i chains trigger i with i+1 (odd bits ignored)
//   trigger_action        1 = enter debug, 0 = breakpoint exception
//   flush_dc4/flush_dc5   kill the op in dc4 / dc5
//   dbg_halt_ack          dec accepts the pending debug request
//   lsu_trigger_match_dc4 chained match, dc4 register
//   lsu_trigger_match_dc5 chained match, dc5, gated by flush_dc5
//   lsu_trigger_hit_dc5   OR of lsu_trigger_match_dc5
//   lsu_trigger_dbg_req   debug-halt request pending
//   lsu_trigger_dbg_id    trigger index owning the pending request
//   lsu_trigger_drop_cnt  saturating count of debug matches dropped while busy
module lsu_trigger_resolve #(
  parameter int NUM_TRIG = 4,
  parameter int ID_W     = 2,
  parameter int DROP_W   = 4
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic [NUM_TRIG-1:0] lsu_trigger_match_dc3,
  input  logic                lsu_pkt_valid_dc3,
  input  logic [NUM_TRIG-1:0] trigger_chain,
  input  logic [NUM_TRIG-1:0] trigger_action,
  input  logic                flush_dc4,
  input  logic                flush_dc5,
  input  logic                dbg_halt_ack,
  output logic [NUM_TRIG-1:0] lsu_trigger_match_dc4,
  output logic [NUM_TRIG-1:0] lsu_trigger_match_dc5,
  output logic                lsu_trigger_hit_dc5,
  output logic                lsu_trigger_dbg_req,
  output logic [ID_W-1:0]     lsu_trigger_dbg_id,
  output logic [DROP_W-1:0]   lsu_trigger_drop_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } dbg_state_e;

  logic [NUM_TRIG-1:0] chained_s;
  logic [NUM_TRIG-1:0] dc4_r;
  logic [NUM_TRIG-1:0] dc5_r;
  logic [NUM_TRIG-1:0] match_dc5_s;
  logic [NUM_TRIG-1:0] dbg_cand_s;
  logic                any_dbg_s;
  logic [ID_W-1:0]     sel_s;
  logic                chain_odd_unused_s;
  dbg_state_e          state_r;
  logic                dbg_req_r;
  logic [ID_W-1:0]     dbg_id_r;
  logic [DROP_W-1:0]   drop_cnt_r;

  // Index of the lowest set bit. The scan goes from high to low so that the
  // lowest index is the last value written.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_TRIG-1:0] v);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Pairwise chaining: a chained pair reports only when both members match.
  always_comb begin
    chained_s = lsu_trigger_match_dc3;
    for (int i = 0; i < NUM_TRIG; i += 2) begin
      if (trigger_chain[i]) begin
        chained_s[i]   = lsu_trigger_match_dc3[i] & lsu_trigger_match_dc3[i+1];
        chained_s[i+1] = lsu_trigger_match_dc3[i] & lsu_trigger_match_dc3[i+1];
      end else begin
        chained_s[i]   = lsu_trigger_match_dc3[i];
        chained_s[i+1] = lsu_trigger_match_dc3[i+1];
      end
    end
  end

  // Odd chain bits have no meaning. They are folded here so that they are visibly consumed.
  always_comb begin
    chain_odd_unused_s = 1'b0;
    for (int i = 1; i < NUM_TRIG; i += 2) begin
      chain_odd_unused_s = chain_odd_unused_s ^ trigger_chain[i];
    end
  end

  // dc5 view and debug candidates. flush_dc5 kills the op in the same cycle.
  always_comb begin
    match_dc5_s = dc5_r & ~{NUM_TRIG{flush_dc5}};
    dbg_cand_s  = match_dc5_s & trigger_action;
    any_dbg_s   = |dbg_cand_s;
    sel_s       = lowest_idx(dbg_cand_s);
  end

  // dc4/dc5 stage registers. They advance every cycle and are never stalled.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dc4_r <= {NUM_TRIG{1'b0}};
      dc5_r <= {NUM_TRIG{1'b0}};
    end else begin
      dc4_r <= chained_s & {NUM_TRIG{lsu_pkt_valid_dc3}};
      dc5_r <= dc4_r & {NUM_TRIG{~flush_dc4}};
    end
  end

  // Debug-halt request handshake. An ack that arrives together with a new
  // candidate re-arms the request at once, so there is no idle bubble.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r    <= ST_IDLE;
      dbg_req_r  <= 1'b0;
      dbg_id_r   <= {ID_W{1'b0}};
      drop_cnt_r <= {DROP_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_dbg_s) begin
            state_r   <= ST_REQ;
            dbg_req_r <= 1'b1;
            dbg_id_r  <= sel_s;
          end else begin
            dbg_req_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (dbg_halt_ack) begin
            if (any_dbg_s) begin
              dbg_id_r <= sel_s;
            end else begin
              state_r   <= ST_IDLE;
              dbg_req_r <= 1'b0;
            end
          end else if (any_dbg_s) begin
            if (drop_cnt_r != {DROP_W{1'b1}}) begin
              drop_cnt_r <= drop_cnt_r + DROP_W'(1);
            end else begin
              drop_cnt_r <= drop_cnt_r;
            end
          end else begin
            dbg_req_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          dbg_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign lsu_trigger_match_dc4 = dc4_r;
  assign lsu_trigger_match_dc5 = match_dc5_s;
  assign lsu_trigger_hit_dc5   = |match_dc5_s;
  assign lsu_trigger_dbg_req   = dbg_req_r;
  assign lsu_trigger_dbg_id    = dbg_id_r;
  assign lsu_trigger_drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_lsu_trigger_resolve.sv
// Bench for lsu_trigger_resolve. The stimulus task advances a reference model
// built from the trigger rules and pushes the outputs expected for each cycle.
// A monitor process pops those expectations at every falling edge and compares
// them with the design outputs.
module tb_lsu_trigger_resolve;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [3:0] raw, chain, action;
  logic       valid, f4, f5, ack;
  logic [3:0] m_dc4, m_dc5, drop;
  logic       hit, req;
  logic [1:0] id;

  always #5 clk = ~clk;

  lsu_trigger_resolve #(.NUM_TRIG(4), .ID_W(2), .DROP_W(4)) dut (
    .clk(clk), .rst_l(rst_l),
    .lsu_trigger_match_dc3(raw), .lsu_pkt_valid_dc3(valid),
    .trigger_chain(chain), .trigger_action(action),
    .flush_dc4(f4), .flush_dc5(f5), .dbg_halt_ack(ack),
    .lsu_trigger_match_dc4(m_dc4), .lsu_trigger_match_dc5(m_dc5),
    .lsu_trigger_hit_dc5(hit), .lsu_trigger_dbg_req(req),
    .lsu_trigger_dbg_id(id), .lsu_trigger_drop_cnt(drop)
  );

  typedef struct {
    logic [3:0] dc4;
    logic [3:0] dc5;
    logic       hit;
    logic       req;
    int         id;
    int         drop;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m4, m5, p_raw, p_chain, p_d;
  logic       p_valid, p_f4, p_ack;
  bit         m_req;
  int         m_id, m_drop;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // A chained pair reports a match only when both of its triggers match.
  function automatic logic [3:0] chain_ref(input logic [3:0] r, input logic [3:0] c);
    logic [3:0] o;
    o = r;
    for (int p = 0; p < 2; p++)
      if (c[2*p]) begin
        o[2*p]   = r[2*p] && r[2*p+1];
        o[2*p+1] = r[2*p] && r[2*p+1];
      end
    return o;
  endfunction

  function automatic int first_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    m4 = 4'h0; m5 = 4'h0; p_raw = 4'h0; p_chain = 4'h0; p_d = 4'h0;
    p_valid = 1'b0; p_f4 = 1'b0; p_ack = 1'b0;
    m_req = 1'b0; m_id = 0; m_drop = 0;
  endtask

  task automatic drive_zero();
    raw = 4'h0; chain = 4'h0; action = 4'h0;
    valid = 1'b0; f4 = 1'b0; f5 = 1'b0; ack = 1'b0;
  endtask

  // Advance one clock, update the model for that edge, apply new inputs and push the expected outputs.
  task automatic step(input logic [3:0] r, input logic v, input logic [3:0] c,
                      input logic [3:0] a, input logic fl4, input logic fl5,
                      input logic ak);
    exp_t e;
    @(posedge clk);
    #1;
    m5 = m4 & ~{4{p_f4}};
    m4 = chain_ref(p_raw, p_chain) & {4{p_valid}};
    if (!m_req) begin
      if (p_d != 4'h0) begin m_req = 1'b1; m_id = first_set(p_d); end
    end else if (p_ack) begin
      if (p_d != 4'h0) m_id = first_set(p_d);
      else m_req = 1'b0;
    end else if (p_d != 4'h0) begin
      m_drop = (m_drop < 15) ? m_drop + 1 : 15;
    end
    raw = r; valid = v; chain = c; action = a; f4 = fl4; f5 = fl5; ack = ak;
    e.dc4  = m4;
    e.dc5  = m5 & ~{4{fl5}};
    e.hit  = (e.dc5 != 4'h0);
    e.req  = m_req;
    e.id   = m_id;
    e.drop = m_drop;
    exp_q.push_back(e);
    p_raw = r; p_valid = v; p_chain = c; p_f4 = fl4; p_ack = ak;
    p_d = e.dc5 & a;
  endtask

  task automatic idle(input int n, input logic [3:0] a);
    for (int i = 0; i < n; i++) step(4'h0, 1'b0, 4'h0, a, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every presented output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("match_dc4", int'(m_dc4), int'(e.dc4));
        check("match_dc5", int'(m_dc5), int'(e.dc5));
        check("hit_dc5", int'(hit), int'(e.hit));
        check("dbg_req", int'(req), int'(e.req));
        if (e.req) check("dbg_id", int'(id), e.id);
        check("drop_cnt", int'(drop), e.drop);
      end
    end
  end

  initial begin
    rst_l = 1'b0;
    drive_zero();
    model_clear();
    #3;
    check("rst_dc4", int'(m_dc4), 0);
    check("rst_dc5", int'(m_dc5), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_req", int'(req), 0);
    check("rst_id", int'(id), 0);
    check("rst_drop", int'(drop), 0);
    @(negedge clk);
    #2 rst_l = 1'b1;

    // Basic latency: dc4 one cycle later, dc5 and hit two cycles later
    step(4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    idle(3, 4'h0);
    // Chaining of pair 0/1; pair 2/3 stays unchained
    step(4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    idle(3, 4'h0);
    // flush_dc4 kills a debug match before it reaches dc5
    step(4'b1000, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0);
    idle(4, 4'b1000);
    // Debug request: lowest candidate index wins; held until ack
    step(4'b0110, 1'b1, 4'b0000, 4'b0110, 1'b0, 1'b0, 1'b0);
    idle(5, 4'b0110);
    step(4'b0000, 1'b0, 4'b0000, 4'b0110, 1'b0, 1'b0, 1'b1);
    idle(3, 4'b0110);
    // Saturation of the drop counter while the request is not acknowledged
    for (int i = 0; i < 25; i++)
      step(4'($urandom_range(1, 15)), 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    idle(3, 4'b1111);
    @(negedge clk);
    check("drop_saturated", int'(drop), 15);
    // ack arriving together with a new candidate keeps the request and moves the id
    step(4'b0100, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    idle(1, 4'b1111);
    step(4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
    idle(2, 4'b1111);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(4'($urandom()), ($urandom_range(0, 3) != 0), 4'($urandom()), 4'($urandom()),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0));

    // Async reset in the middle of a pending request
    idle(3, 4'h0);
    step(4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    idle(3, 4'b0001);
    @(negedge clk);
    check("req_before_reset", int'(req), 1);
    #2 rst_l = 1'b0;
    drive_zero();
    model_clear();
    #1;
    check("async_rst_req", int'(req), 0);
    check("async_rst_dc4", int'(m_dc4), 0);
    check("async_rst_dc5", int'(m_dc5), 0);
    check("async_rst_drop", int'(drop), 0);
    #10 rst_l = 1'b1;
    idle(4, 4'h0);
    step(4'b0010, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0);
    idle(5, 4'b0010);

    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
